// File: rtl/hier_seq_pkg.sv
// Shared types and helpers for the hier_seq_node hierarchy level.
package hier_seq_pkg;

  // Node sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Load value for child idx: (base + idx) modulo 2^cnt_w.
  // The result is 32 bits wide; callers cast it down to their counter width.
  function automatic logic [31:0] child_load(input logic [31:0] base,
                                             input int unsigned idx,
                                             input int unsigned cnt_w);
    logic [31:0] sum;
    logic [31:0] mask;
    sum = base + idx;
    if (cnt_w >= 32) begin
      mask = '1;
    end else begin
      mask = (32'd1 << cnt_w) - 32'd1;
    end
    return sum & mask;
  endfunction

endpackage

// File: rtl/hier_seq_leaf.sv
// Leaf worker: a start pulse loads a down-counter. done_o is high for
// exactly one cycle, load+1 cycles after the start cycle. A start that
// arrives while the leaf is counting is ignored.
module hier_seq_leaf #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Next-state logic: load on start when idle, count down while active,
  // and drop active in the cycle the count reaches zero.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    cnt_d    = cnt_q;
    active_d = active_q;
    if (!active_q) begin
      if (start_i) begin
        cnt_d    = load_i;
        active_d = 1'b1;
      end
    end else if (cnt_q == '0) begin
      active_d = 1'b0;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and activity registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the pre-edge value of its inputs.
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/hier_seq_node.sv
// Hierarchy node: launches NUM_CHILD leaf workers either one after another
// (PAR_MODE=0) or all together (PAR_MODE=1), gathers their completions into
// a sticky mask, counts cycles spent in RUN (saturating) and raises a
// single done pulse once every child has finished.
module hier_seq_node
  import hier_seq_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int CNT_W     = 8,
  parameter int ELAPSED_W = 16,
  parameter int PAR_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     load_val,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CHILD-1:0] child_done_mask,
  output logic [ELAPSED_W-1:0] elapsed
);

  localparam int PTR_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CHILD - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     load_q, load_d;
  logic [NUM_CHILD-1:0] start_q, start_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_CHILD-1:0] mask_q, mask_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic [NUM_CHILD-1:0] leaf_done;

  // FSM next state, launch sequencing, completion mask and elapsed count.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    start_d   = '0;
    ptr_d     = ptr_q;
    mask_d    = mask_q;
    elapsed_d = elapsed_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          load_d    = load_val;
          mask_d    = '0;
          elapsed_d = '0;
          ptr_d     = '0;
          if (PAR_MODE != 0) begin
            start_d = '1;
          end else begin
            start_d[0] = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (elapsed_q != '1) begin
          elapsed_d = elapsed_q + 1'b1;
        end
        mask_d = mask_q | leaf_done;
        // Sequential mode: the child after the one that just finished is
        // started in the following cycle.
        if ((PAR_MODE == 0) && leaf_done[ptr_q] && (ptr_q != LAST_PTR)) begin
          ptr_d                 = ptr_q + 1'b1;
          start_d[ptr_q + 1'b1] = 1'b1;
        end
        if (&mask_d) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      load_q    <= '0;
      start_q   <= '0;
      ptr_q     <= '0;
      mask_q    <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      start_q   <= start_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      elapsed_q <= elapsed_d;
    end
  end

  // One leaf per child, each loaded with (captured base + index) wrapped.
  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_child
    logic [CNT_W-1:0] child_load_w;
    assign child_load_w = CNT_W'(child_load(32'(load_q), 32'(i), CNT_W));

    hier_seq_leaf #(
      .CNT_W(CNT_W)
    ) u_leaf (
      .clk    (clk),
      .rst    (rst),
      .start_i(start_q[i]),
      .load_i (child_load_w),
      .done_o (leaf_done[i])
    );
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign child_done_mask = mask_q;
  assign elapsed         = elapsed_q;

endmodule

// File: tb/tb_hier_seq_node.sv
// Bench for hier_seq_node: three instances (sequential, parallel, sequential
// with a 4-bit elapsed counter) driven one at a time and checked every
// cycle against completion times derived arithmetically from the load values.
module tb_hier_seq_node;

  localparam int N  = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    start_v;
  logic [CW-1:0] lv_v [3];
  logic [2:0]    busy_v;
  logic [2:0]    done_v;
  logic [N-1:0]  mask_v [3];
  logic [15:0]   el0, el1;
  logic [3:0]    el2;

  int errors = 0;
  int checks = 0;

  hier_seq_node #(.NUM_CHILD(N), .CNT_W(CW), .ELAPSED_W(16), .PAR_MODE(0)) u_seq (
    .clk(clk), .rst(rst), .start(start_v[0]), .load_val(lv_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .child_done_mask(mask_v[0]), .elapsed(el0));

  hier_seq_node #(.NUM_CHILD(N), .CNT_W(CW), .ELAPSED_W(16), .PAR_MODE(1)) u_par (
    .clk(clk), .rst(rst), .start(start_v[1]), .load_val(lv_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .child_done_mask(mask_v[1]), .elapsed(el1));

  hier_seq_node #(.NUM_CHILD(N), .CNT_W(CW), .ELAPSED_W(4), .PAR_MODE(0)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[2]), .load_val(lv_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .child_done_mask(mask_v[2]), .elapsed(el2));

  function automatic int get_el(input int sel);
    case (sel)
      0:       return int'(el0);
      1:       return int'(el1);
      default: return int'(el2);
    endcase
  endfunction

  // Compares all four outputs of instance sel against expected values.
  task automatic cmp_all(input string tag, input int sel, input int cyc,
                         input bit e_busy, input bit e_done,
                         input logic [N-1:0] e_mask, input int e_el);
    checks++;
    if (busy_v[sel] !== e_busy) begin
      errors++;
      $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy_v[sel], e_busy);
    end
    checks++;
    if (done_v[sel] !== e_done) begin
      errors++;
      $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, done_v[sel], e_done);
    end
    checks++;
    if (mask_v[sel] !== e_mask) begin
      errors++;
      $display("FAIL %s mask cyc=%0d got=%b exp=%b", tag, cyc, mask_v[sel], e_mask);
    end
    checks++;
    if (get_el(sel) !== e_el) begin
      errors++;
      $display("FAIL %s elapsed cyc=%0d got=%0d exp=%0d", tag, cyc, get_el(sel), e_el);
    end
  endtask

  // One run on instance sel with base lv. Cycle 0 is the cycle start is
  // sampled in IDLE. Child finish cycles come from the timing rules:
  // sequential d_i = sum_{j<=i} L_j + 2(i+1); parallel d_i = L_i + 2;
  // top-level done one cycle after the last child. start is re-pulsed
  // (to be ignored) in cycles ign_a/ign_b. started=1 means the previous run
  // already held start high in this run's cycle 0; hold_out=1 keeps start
  // high in the first IDLE cycle after DONE with load_val=next_lv.
  task automatic do_run(input string tag, input int sel, input int lv,
                        input int ign_a, input int ign_b, input bit started,
                        input bit hold_out, input int next_lv);
    int ld[N];
    int d[N];
    int acc = 0;
    int t = 0;
    int sat;
    int last_c;
    int e_el;
    logic [N-1:0] e_mask;
    bit par;
    par = (sel == 1);
    sat = (sel == 2) ? 15 : 65535;
    for (int i = 0; i < N; i++) begin
      ld[i] = (lv + i) % 256;
      if (par) begin
        d[i] = ld[i] + 2;
      end else begin
        acc += ld[i] + 2;
        d[i] = acc;
      end
      if (d[i] > t) t = d[i];
    end
    t = t + 1;
    if (!started) begin
      @(negedge clk);
      checks++;
      if (busy_v[sel] !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_before_start got=%b exp=0", tag, busy_v[sel]);
      end
      start_v[sel] = 1'b1;
      lv_v[sel]    = CW'(lv);
    end
    last_c = hold_out ? t + 1 : t + 2;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == t + 1) begin
        start_v[sel] = hold_out;
        lv_v[sel]    = CW'(next_lv);
      end else begin
        start_v[sel] = (c == ign_a) || (c == ign_b);
        lv_v[sel]    = CW'($urandom);
      end
      for (int i = 0; i < N; i++) e_mask[i] = (c > d[i]);
      e_el = ((c < t) ? c : t) - 1;
      if (e_el > sat) e_el = sat;
      cmp_all(tag, sel, c, (c <= t), (c == t), e_mask, e_el);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_v = 3'b111;
    for (int s = 0; s < 3; s++) lv_v[s] = 8'd9;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) cmp_all("reset", s, 0, 1'b0, 1'b0, '0, 0);
    start_v = '0;
    rst = 1'b0;
  endtask

  task automatic test_seq_basic;
    do_run("seq_lv2", 0, 2, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_par_basic;
    do_run("par_lv2", 1, 2, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_wrap;
    do_run("par_wrap", 1, 254, 0, 0, 1'b0, 1'b0, 0);
    do_run("seq_wrap", 0, 253, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ignored_start;
    do_run("seq_ign", 0, 2, 5, 31, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start_v[0] = 1'b1;
    lv_v[0]    = 8'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (c == 5) cmp_all("rst_mid_live", 0, c, 1'b1, 1'b0, 5'b00001, 4);
      if (c == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    cmp_all("rst_mid_after", 0, 11, 1'b0, 1'b0, '0, 0);
    for (int c = 12; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet cyc=%0d got busy=%b done=%b exp 0/0", c, busy_v[0], done_v[0]);
      end
    end
    do_run("seq_fresh", 0, 2, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_saturation;
    do_run("sat_lv20", 2, 20, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    do_run("hold_a", 0, 3, 0, 0, 1'b0, 1'b1, 7);
    do_run("hold_b", 0, 7, 0, 0, 1'b1, 1'b1, 250);
    do_run("hold_c", 0, 250, 0, 0, 1'b1, 1'b0, 0);
    do_run("hold_p", 1, 6, 0, 0, 1'b0, 1'b1, 1);
    do_run("hold_q", 1, 1, 0, 0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random;
    int sel;
    int lv;
    int ia;
    int ib;
    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, 2));
      lv  = int'($urandom_range(0, 255));
      ia  = int'($urandom_range(1, 6));
      ib  = int'($urandom_range(0, 6));
      do_run("rand", sel, lv, ia, ib, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_v = '0;
    for (int s = 0; s < 3; s++) lv_v[s] = '0;
    test_reset;
    test_seq_basic;
    test_par_basic;
    test_wrap;
    test_ignored_start;
    test_reset_mid_run;
    test_saturation;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
